// File: rtl/instruction_fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage: FSM states, pre-decode codes,
// opcode values and the IF/ID register layout.
package instruction_fetch_stage_pkg;

    typedef enum logic [1:0] {
        StFetch   = 2'd0,
        StHold    = 2'd1,
        StDiscard = 2'd2
    } fetch_state_e;

    localparam logic [1:0] BjNone   = 2'b00;
    localparam logic [1:0] BjBranch = 2'b01;
    localparam logic [1:0] BjJal    = 2'b10;
    localparam logic [1:0] BjJalr   = 2'b11;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmU = 3'b011;
    localparam logic [2:0] ImmJ = 3'b100;

    // Opcode values are instr[6:2]; instr[1:0] must be 2'b11 for a 32-bit encoding.
    localparam logic [4:0] OpcBranch = 5'b11000;
    localparam logic [4:0] OpcJal    = 5'b11011;
    localparam logic [4:0] OpcJalr   = 5'b11001;
    localparam logic [4:0] OpcStore  = 5'b01000;
    localparam logic [4:0] OpcLui    = 5'b01101;
    localparam logic [4:0] OpcAuipc  = 5'b00101;

    localparam logic [31:0] NopInstrDefault = 32'h0000_0013;

    typedef struct packed {
        logic [29:0] instr;
        logic [29:0] pc;
        logic [1:0]  bj_op;
        logic [2:0]  imm_src;
        logic        fault;
    } if_id_t;

endpackage

// File: rtl/fetch_predecoder.sv
// Combinational pre-decode of a fetched word: control-transfer class, immediate format and a
// flag for words that are not 32-bit encodings.
module fetch_predecoder
    import instruction_fetch_stage_pkg::*;
(
    input  logic [6:0] instr_lo_i,
    output logic [1:0] branch_jump_op_o,
    output logic [2:0] imm_src_o,
    output logic       fault_o
);

    logic [4:0] opcode;

    assign opcode  = instr_lo_i[6:2];
    assign fault_o = (instr_lo_i[1:0] != 2'b11);

    always_comb begin
        branch_jump_op_o = BjNone;
        imm_src_o        = ImmI;
        case (opcode)
            OpcBranch: begin
                branch_jump_op_o = BjBranch;
                imm_src_o        = ImmB;
            end
            OpcJal: begin
                branch_jump_op_o = BjJal;
                imm_src_o        = ImmJ;
            end
            OpcJalr: begin
                branch_jump_op_o = BjJalr;
                imm_src_o        = ImmI;
            end
            OpcStore: imm_src_o = ImmS;
            OpcLui, OpcAuipc: imm_src_o = ImmU;
            default: ;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: drives the instruction memory, keeps a one-entry skid buffer for
// words returned while IF/ID is frozen, and discards responses made stale by a redirect.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = NopInstrDefault
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [29:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    input  logic        busywait_i,
    input  logic        stall_if_i,
    input  logic        branching_i,
    input  logic [29:0] branch_target_i,
    output logic [29:0] instr_o,
    output logic [29:0] pc_o,
    output logic [1:0]  branch_jump_op_o,
    output logic [2:0]  imm_src_o,
    output logic        fetch_fault_o
);

    fetch_state_e state_q, state_d;
    logic [29:0]  pc_q, pc_d;
    logic [29:0]  disc_addr_q, disc_addr_d;
    logic [31:0]  buf_word_q, buf_word_d;
    logic [29:0]  buf_pc_q, buf_pc_d;
    if_id_t       ifid_q, ifid_d;

    logic         advance;
    logic         ifid_load;
    logic         ifid_bubble;
    logic [31:0]  load_word;
    logic [29:0]  load_pc;
    logic [1:0]   dec_bj_op;
    logic [2:0]   dec_imm_src;
    logic         dec_fault;
    if_id_t       bubble_entry;
    if_id_t       load_entry;

    assign advance   = !busywait_i && !stall_if_i && !branching_i;
    assign load_word = (state_q == StHold) ? buf_word_q : imem_data_i;
    assign load_pc   = (state_q == StHold) ? buf_pc_q : pc_q;

    fetch_predecoder u_predecoder (
        .instr_lo_i       (load_word[6:0]),
        .branch_jump_op_o (dec_bj_op),
        .imm_src_o        (dec_imm_src),
        .fault_o          (dec_fault)
    );

    assign bubble_entry = '{instr: NOP_INSTR[31:2], pc: 30'd0, bj_op: BjNone, imm_src: ImmI,
                            fault: 1'b0};
    assign load_entry   = '{instr: load_word[31:2], pc: load_pc, bj_op: dec_bj_op,
                            imm_src: dec_imm_src, fault: dec_fault};

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        disc_addr_d = disc_addr_q;
        buf_word_d  = buf_word_q;
        buf_pc_d    = buf_pc_q;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;

        if (branching_i) begin
            ifid_bubble = 1'b1;
            pc_d        = branch_target_i;
            buf_word_d  = '0;
            buf_pc_d    = '0;
        end

        case (state_q)
            StFetch: begin
                if (branching_i) begin
                    // Request still in flight: its response must be swallowed later.
                    if (!imem_ack_i) begin
                        state_d     = StDiscard;
                        disc_addr_d = pc_q;
                    end
                end else if (imem_ack_i) begin
                    pc_d = pc_q + 30'd1;
                    if (advance) begin
                        ifid_load = 1'b1;
                    end else begin
                        buf_word_d = imem_data_i;
                        buf_pc_d   = pc_q;
                        state_d    = StHold;
                    end
                end else if (advance) begin
                    ifid_bubble = 1'b1;
                end
            end
            StHold: begin
                if (branching_i) begin
                    state_d = StFetch;
                end else if (advance) begin
                    ifid_load  = 1'b1;
                    buf_word_d = '0;
                    buf_pc_d   = '0;
                    state_d    = StFetch;
                end
            end
            StDiscard: begin
                if (advance) begin
                    ifid_bubble = 1'b1;
                end
                if (imem_ack_i) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        ifid_d = ifid_q;
        if (ifid_bubble) begin
            ifid_d = bubble_entry;
        end else if (ifid_load) begin
            ifid_d = load_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StFetch;
            pc_q        <= RESET_VECTOR[31:2];
            disc_addr_q <= '0;
            buf_word_q  <= '0;
            buf_pc_q    <= '0;
            ifid_q      <= bubble_entry;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            disc_addr_q <= disc_addr_d;
            buf_word_q  <= buf_word_d;
            buf_pc_q    <= buf_pc_d;
            ifid_q      <= ifid_d;
        end
    end

    // While discarding, keep presenting the address of the stale request until it is acked.
    assign imem_req_o  = !rst_i && (state_q != StHold);
    assign imem_addr_o = (state_q == StDiscard) ? disc_addr_q : pc_q;

    assign instr_o          = ifid_q.instr;
    assign pc_o             = ifid_q.pc;
    assign branch_jump_op_o = ifid_q.bj_op;
    assign imm_src_o        = ifid_q.imm_src;
    assign fetch_fault_o    = ifid_q.fault;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: decode vector table, directed stall/redirect/
// reset sequences, then randomized traffic checked against an instruction-stream model.
module tb_instruction_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [29:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic        busywait_i;
    logic        stall_if_i;
    logic        branching_i;
    logic [29:0] branch_target_i;
    logic [29:0] instr_o;
    logic [29:0] pc_o;
    logic [1:0]  branch_jump_op_o;
    logic [2:0]  imm_src_o;
    logic        fetch_fault_o;

    int n_cmp = 0;
    int n_bad = 0;

    instruction_fetch_stage dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ack_i       (imem_ack_i),
        .imem_data_i      (imem_data_i),
        .busywait_i       (busywait_i),
        .stall_if_i       (stall_if_i),
        .branching_i      (branching_i),
        .branch_target_i  (branch_target_i),
        .instr_o          (instr_o),
        .pc_o             (pc_o),
        .branch_jump_op_o (branch_jump_op_o),
        .imm_src_o        (imm_src_o),
        .fetch_fault_o    (fetch_fault_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] word;
        logic [1:0]  bj;
        logic [2:0]  imm;
        logic        fault;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] nop_w = 32'h0000_0013;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode table: {branch_jump_op[1:0], imm_src[2:0], fault}.
    function automatic logic [5:0] ref_decode(input logic [31:0] w);
        logic [1:0] bj;
        logic [2:0] imm;
        logic [4:0] opc;
        opc = w[6:2];
        bj  = 2'b00;
        imm = 3'b000;
        if (opc == 5'b11000) begin bj = 2'b01; imm = 3'b010; end
        else if (opc == 5'b11011) begin bj = 2'b10; imm = 3'b100; end
        else if (opc == 5'b11001) begin bj = 2'b11; imm = 3'b000; end
        else if (opc == 5'b01000) imm = 3'b001;
        else if (opc == 5'b01101 || opc == 5'b00101) imm = 3'b011;
        return {bj, imm, (w[1:0] != 2'b11)};
    endfunction

    // Memory contents: pseudo-random per address, bit 31 always set so no word looks like a NOP.
    function automatic logic [31:0] word_at(input logic [29:0] a);
        logic [31:0] h;
        logic [4:0]  opcs[8];
        logic [1:0]  low;
        opcs = '{5'b11000, 5'b11011, 5'b11001, 5'b01000, 5'b01101, 5'b00101, 5'b00100, 5'b01100};
        h   = ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        low = (h[15:12] == 4'd0) ? h[1:0] : 2'b11;
        return {1'b1, h[30:7], opcs[h[10:8]], low};
    endfunction

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, 64'(instr_o), 64'(nop_w[31:2]));
        check({tag, "_pc"}, 64'(pc_o), 64'd0);
        check({tag, "_bj"}, 64'(branch_jump_op_o), 64'd0);
        check({tag, "_imm"}, 64'(imm_src_o), 64'd0);
        check({tag, "_fault"}, 64'(fetch_fault_o), 64'd0);
    endtask

    task automatic check_entry(input string tag, input logic [29:0] a, input logic [31:0] w);
        logic [5:0] d;
        d = ref_decode(w);
        check({tag, "_pc"}, 64'(pc_o), 64'(a));
        check({tag, "_instr"}, 64'(instr_o), 64'(w[31:2]));
        check({tag, "_bj"}, 64'(branch_jump_op_o), 64'(d[5:4]));
        check({tag, "_imm"}, 64'(imm_src_o), 64'(d[3:1]));
        check({tag, "_fault"}, 64'(fetch_fault_o), 64'(d[0]));
    endtask

    task automatic do_reset();
        rst_i           = 1'b1;
        imem_ack_i      = 1'b0;
        imem_data_i     = '0;
        busywait_i      = 1'b0;
        stall_if_i      = 1'b0;
        branching_i     = 1'b0;
        branch_target_i = '0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
    endtask

    logic [29:0] exp_pc;
    int          n_instr;
    int          mem_wait;
    logic        p_branch, p_adv, p_req, p_ack;
    logic [29:0] p_target, p_addr;
    logic [29:0] s_instr, s_pc;
    logic [1:0]  s_bj;
    logic [2:0]  s_imm;
    logic        s_fault;
    logic [31:0] w;

    initial begin
        vecs[0] = '{32'h1234_506F, 2'b10, 3'b100, 1'b0};  // JAL
        vecs[1] = '{32'h0000_0001, 2'b00, 3'b000, 1'b1};  // compressed -> fault
        vecs[2] = '{32'hABCD_0063, 2'b01, 3'b010, 1'b0};  // branch
        vecs[3] = '{32'h0040_8067, 2'b11, 3'b000, 1'b0};  // JALR
        vecs[4] = '{32'h00A1_2023, 2'b00, 3'b001, 1'b0};  // store
        vecs[5] = '{32'h1234_5037, 2'b00, 3'b011, 1'b0};  // LUI
        vecs[6] = '{32'h0000_1017, 2'b00, 3'b011, 1'b0};  // AUIPC
        vecs[7] = '{32'h00B5_0533, 2'b00, 3'b000, 1'b0};  // add

        // Reset state and single-cycle-ack streaming through the decode table.
        rst_i = 1'b1;
        imem_ack_i = 1'b0; imem_data_i = '0; busywait_i = 1'b0; stall_if_i = 1'b0;
        branching_i = 1'b0; branch_target_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_req", 64'(imem_req_o), 64'd0);
        check_bubble("rst");
        rst_i = 1'b0;
        #1;
        check("post_rst_req", 64'(imem_req_o), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("seq_addr%0d", i), 64'(imem_addr_o), 64'(i));
            imem_ack_i  = 1'b1;
            imem_data_i = vecs[i].word;
            @(negedge clk_i);
            check($sformatf("vec%0d_pc", i), 64'(pc_o), 64'(i));
            check($sformatf("vec%0d_instr", i), 64'(instr_o), 64'(vecs[i].word[31:2]));
            check($sformatf("vec%0d_bj", i), 64'(branch_jump_op_o), 64'(vecs[i].bj));
            check($sformatf("vec%0d_imm", i), 64'(imm_src_o), 64'(vecs[i].imm));
            check($sformatf("vec%0d_fault", i), 64'(fetch_fault_o), 64'(vecs[i].fault));
        end
        imem_ack_i = 1'b0;

        // Load-use stall while the word at address 5 is returned.
        do_reset();
        for (int a = 0; a < 5; a++) begin
            imem_ack_i  = 1'b1;
            imem_data_i = word_at(imem_addr_o);
            @(negedge clk_i);
        end
        check("stall_addr5", 64'(imem_addr_o), 64'd5);
        imem_ack_i = 1'b1; imem_data_i = word_at(30'd5); stall_if_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        w = word_at(30'd4);
        check("stall_c1_req", 64'(imem_req_o), 64'd0);
        check("stall_c1_pc", 64'(pc_o), 64'd4);
        check("stall_c1_instr", 64'(instr_o), 64'(w[31:2]));
        @(negedge clk_i);
        check("stall_c2_req", 64'(imem_req_o), 64'd0);
        check("stall_c2_instr", 64'(instr_o), 64'(w[31:2]));
        stall_if_i = 1'b0;
        @(negedge clk_i);
        check_entry("stall_resume", 30'd5, word_at(30'd5));
        check("stall_resume_req", 64'(imem_req_o), 64'd1);
        check("stall_resume_addr", 64'(imem_addr_o), 64'd6);

        // Redirect with the response arriving in the same cycle.
        branching_i = 1'b1; branch_target_i = 30'h40; imem_ack_i = 1'b1;
        imem_data_i = word_at(30'd6);
        @(negedge clk_i);
        branching_i = 1'b0; imem_ack_i = 1'b0;
        check_bubble("br_ack");
        check("br_ack_addr", 64'(imem_addr_o), 64'h40);
        check("br_ack_req", 64'(imem_req_o), 64'd1);

        // Redirect with a request outstanding at 7, second redirect mid-discard, ack 3 cycles on.
        branching_i = 1'b1; branch_target_i = 30'd7; imem_ack_i = 1'b1;
        imem_data_i = word_at(30'h40);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check("disc_start_addr", 64'(imem_addr_o), 64'd7);
        branch_target_i = 30'h40;
        @(negedge clk_i);
        check("disc_c1_req", 64'(imem_req_o), 64'd1);
        check("disc_c1_addr", 64'(imem_addr_o), 64'd7);
        check_bubble("disc_c1");
        branch_target_i = 30'h50;
        @(negedge clk_i);
        branching_i = 1'b0;
        check("disc_c2_addr", 64'(imem_addr_o), 64'd7);
        @(negedge clk_i);
        check("disc_c3_req", 64'(imem_req_o), 64'd1);
        check("disc_c3_addr", 64'(imem_addr_o), 64'd7);
        imem_ack_i = 1'b1; imem_data_i = word_at(30'd7);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check_bubble("disc_drop");
        check("disc_done_addr", 64'(imem_addr_o), 64'h50);
        check("disc_done_req", 64'(imem_req_o), 64'd1);
        imem_ack_i = 1'b1; imem_data_i = word_at(30'h50);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check_entry("disc_target", 30'h50, word_at(30'h50));

        // Reset while holding a buffered word.
        imem_ack_i = 1'b1; imem_data_i = word_at(30'h51); busywait_i = 1'b1;
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check("hold_req", 64'(imem_req_o), 64'd0);
        busywait_i = 1'b0; rst_i = 1'b1;
        @(negedge clk_i);
        check("hold_rst_req", 64'(imem_req_o), 64'd0);
        check_bubble("hold_rst");
        rst_i = 1'b0;
        #1;
        check("hold_rst_addr", 64'(imem_addr_o), 64'd0);
        check("hold_rst_req1", 64'(imem_req_o), 64'd1);
        @(negedge clk_i);
        check_bubble("hold_rst_empty");
        imem_ack_i = 1'b1; imem_data_i = word_at(30'd0);
        @(negedge clk_i);
        imem_ack_i = 1'b0;
        check_entry("hold_rst_first", 30'd0, word_at(30'd0));

        // Randomized traffic against the in-order instruction-stream model.
        do_reset();
        exp_pc   = '0;
        n_instr  = 0;
        mem_wait = -1;
        for (int c = 0; c < 3000; c++) begin
            s_instr = instr_o; s_pc = pc_o; s_bj = branch_jump_op_o;
            s_imm = imm_src_o; s_fault = fetch_fault_o;
            p_req  = imem_req_o;
            p_addr = imem_addr_o;
            if (imem_req_o) begin
                if (mem_wait < 0) mem_wait = int'($urandom_range(0, 2));
                if (mem_wait == 0) begin
                    imem_ack_i  = 1'b1;
                    imem_data_i = word_at(imem_addr_o);
                    mem_wait    = -1;
                end else begin
                    imem_ack_i  = 1'b0;
                    imem_data_i = $urandom;
                    mem_wait--;
                end
            end else begin
                imem_ack_i = 1'b0;
            end
            p_ack           = imem_ack_i;
            branching_i     = ($urandom_range(0, 19) == 0);
            branch_target_i = 30'($urandom_range(0, 255));
            stall_if_i      = ($urandom_range(0, 4) == 0);
            busywait_i      = ($urandom_range(0, 5) == 0);
            p_branch = branching_i;
            p_target = branch_target_i;
            p_adv    = !busywait_i && !stall_if_i && !branching_i;
            @(negedge clk_i);
            if (p_req && !p_ack && imem_req_o) begin
                check("rnd_addr_stable", 64'(imem_addr_o), 64'(p_addr));
            end
            if (p_branch) begin
                check_bubble("rnd_branch");
                exp_pc = p_target;
            end else if (p_adv) begin
                if (!(pc_o == 30'd0 && instr_o == nop_w[31:2])) begin
                    check_entry("rnd_stream", exp_pc, word_at(exp_pc));
                    exp_pc = exp_pc + 30'd1;
                    n_instr++;
                end
            end else begin
                check("rnd_frozen_instr", 64'(instr_o), 64'(s_instr));
                check("rnd_frozen_pc", 64'(pc_o), 64'(s_pc));
                check("rnd_frozen_ctl", 64'({branch_jump_op_o, imm_src_o, fetch_fault_o}),
                      64'({s_bj, s_imm, s_fault}));
            end
        end
        check("rnd_progress", 64'(n_instr > 300), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
